// File: rtl/bus_slave_sel_pkg.sv
// Shared types and constants for the bus slave selector and its watchdog.
// Imported by the top level; state and error-cause encodings live here.
package bus_slave_sel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ERROR  = 2'd2
   } state_t;

   localparam logic CAUSE_UNMAPPED = 1'b0;
   localparam logic CAUSE_TIMEOUT  = 1'b1;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Slave-ready watchdog counter: synchronous clear, count enable and a
// terminal-count flag. Kept generic so the arbiter can reuse it.
module bus_timeout_cnt #(
   parameter int CNT_W    = 8,
   parameter int TERMINAL = 254
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == CNT_W'(TERMINAL));

endmodule

// File: rtl/bus_slave_sel.sv
// Registered slave decoder: holds an active-low chip select for the whole
// access, watches slave ready, and produces bus-error completions with a sticky log.
module bus_slave_sel
   import bus_slave_sel_pkg::*;
#(
   parameter int ADDR_W     = 30,
   parameter int NUM_SLAVES = 8,
   parameter int IDX_W      = 3,
   parameter int TIMEOUT    = 255,
   parameter int TO_CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     mAddr,
   input  logic                  mAS_,
   input  logic [NUM_SLAVES-1:0] sRdy_,
   output logic [NUM_SLAVES-1:0] sCS_,
   output logic                  mRdy_,
   output logic                  busErr,
   output logic                  errValid,
   output logic [ADDR_W-1:0]     errAddr,
   output logic                  errCause,
   input  logic                  errClr
);

   // One extra bit so NUM_SLAVES == 2**IDX_W still compares correctly.
   localparam logic [IDX_W:0] NUM_SLV = (IDX_W + 1)'(NUM_SLAVES);

   state_t                r_state;
   state_t                w_state_next;
   logic [NUM_SLAVES-1:0] r_cs_n;
   logic [NUM_SLAVES-1:0] w_cs_n_next;
   logic [NUM_SLAVES-1:0] w_dec_n;
   logic [ADDR_W-1:0]     r_addr;
   logic [ADDR_W-1:0]     r_err_addr;
   logic                  r_err_valid;
   logic                  r_err_cause;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_mapped;
   logic                  w_rdy;
   logic                  w_tc;
   logic                  w_mrdy_n;
   logic                  w_bus_err;
   logic                  w_err_entry;
   logic                  w_err_cause;
   logic [ADDR_W-1:0]     w_err_addr;

   assign w_idx    = mAddr[ADDR_W-1 -: IDX_W];
   assign w_mapped = ({1'b0, w_idx} < NUM_SLV);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
         assign w_dec_n[gi] = (w_idx != IDX_W'(gi));
      end
   endgenerate

   // Only the slave whose select is low can complete the access.
   assign w_rdy = |(~sRdy_ & ~r_cs_n);

   bus_timeout_cnt #(
      .CNT_W    (TO_CNT_W),
      .TERMINAL (TIMEOUT - 1)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .i_clr (r_state != ST_ACCESS),
      .i_en  (r_state == ST_ACCESS),
      .o_tc  (w_tc)
   );

   always_comb begin
      w_state_next = r_state;
      w_cs_n_next  = r_cs_n;
      w_mrdy_n     = 1'b1;
      w_bus_err    = 1'b0;
      w_err_entry  = 1'b0;
      w_err_cause  = CAUSE_UNMAPPED;
      w_err_addr   = r_addr;
      case (r_state)
         ST_IDLE: begin
            if (!mAS_) begin
               if (w_mapped) begin
                  w_state_next = ST_ACCESS;
                  w_cs_n_next  = w_dec_n;
               end else begin
                  w_state_next = ST_ERROR;
                  w_err_entry  = 1'b1;
                  w_err_cause  = CAUSE_UNMAPPED;
                  w_err_addr   = mAddr;
               end
            end
         end
         ST_ACCESS: begin
            // Abort beats ready, and ready beats the watchdog.
            if (mAS_) begin
               w_state_next = ST_IDLE;
               w_cs_n_next  = '1;
            end else if (w_rdy) begin
               w_mrdy_n     = 1'b0;
               w_state_next = ST_IDLE;
               w_cs_n_next  = '1;
            end else if (w_tc) begin
               w_state_next = ST_ERROR;
               w_cs_n_next  = '1;
               w_err_entry  = 1'b1;
               w_err_cause  = CAUSE_TIMEOUT;
            end
         end
         ST_ERROR: begin
            w_mrdy_n     = 1'b0;
            w_bus_err    = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cs_n_next  = '1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cs_n  <= '1;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cs_n  <= w_cs_n_next;
         if (r_state == ST_IDLE && !mAS_) begin
            r_addr <= mAddr;
         end
      end
   end

   // First error is kept until cleared; a clear coinciding with a new error logs the new one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_cause <= 1'b0;
      end else if (w_err_entry && (!r_err_valid || errClr)) begin
         r_err_valid <= 1'b1;
         r_err_addr  <= w_err_addr;
         r_err_cause <= w_err_cause;
      end else if (errClr) begin
         r_err_valid <= 1'b0;
      end
   end

   assign sCS_     = r_cs_n;
   assign mRdy_    = w_mrdy_n;
   assign busErr   = w_bus_err;
   assign errValid = r_err_valid;
   assign errAddr  = r_err_addr;
   assign errCause = r_err_cause;

   a_cs_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(~sCS_));

endmodule

// File: tb/tb_bus_slave_sel.sv
// Directed bench for bus_slave_sel (6 slaves, watchdog of 4 cycles): stimulus
// queues expected completions, a negedge monitor checks each mRdy_ against them.
module tb_bus_slave_sel;

   localparam int AW = 30;
   localparam int NS = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] mAddr;
   logic          mAS_;
   logic [NS-1:0] sRdy_;
   logic [NS-1:0] sCS_;
   logic          mRdy_;
   logic          busErr;
   logic          errValid;
   logic [AW-1:0] errAddr;
   logic          errCause;
   logic          errClr;

   bus_slave_sel #(
      .ADDR_W     (AW),
      .NUM_SLAVES (NS),
      .IDX_W      (3),
      .TIMEOUT    (4),
      .TO_CNT_W   (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .mAddr    (mAddr),
      .mAS_     (mAS_),
      .sRdy_    (sRdy_),
      .sCS_     (sCS_),
      .mRdy_    (mRdy_),
      .busErr   (busErr),
      .errValid (errValid),
      .errAddr  (errAddr),
      .errCause (errCause),
      .errClr   (errClr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int            cyc;
      logic          be;
      logic [NS-1:0] cs;
      logic          ev;
      logic [AW-1:0] ea;
      logic          ec;
   } exp_t;

   exp_t sb[$];

   // Hand-maintained expectation of the error log.
   logic          m_ev;
   logic [AW-1:0] m_ea;
   logic          m_ec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_done(input int lat, input logic be, input logic [NS-1:0] cs);
      sb.push_back('{cyc + lat, be, cs, m_ev, m_ea, m_ec});
   endtask

   task automatic chk_reset_vals(input string tag);
      @(negedge clk);
      chk({tag, "_sCS"}, 32'(sCS_), 32'h3F);
      chk({tag, "_mRdy"}, 32'(mRdy_), 32'd1);
      chk({tag, "_busErr"}, 32'(busErr), 32'd0);
      chk({tag, "_errValid"}, 32'(errValid), 32'd0);
      chk({tag, "_errAddr"}, 32'(errAddr), 32'd0);
      chk({tag, "_errCause"}, 32'(errCause), 32'd0);
   endtask

   function automatic logic [AW-1:0] mk_addr(input logic [2:0] idx, input logic [26:0] low);
      return {idx, low};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && mRdy_ === 1'b0) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_mrdy: mRdy_ low at cycle %0d, none expected", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("done_busErr", 32'(busErr), 32'(e.be));
            chk("done_sCS", 32'(sCS_), 32'(e.cs));
            chk("done_errValid", 32'(errValid), 32'(e.ev));
            chk("done_errAddr", 32'(errAddr), 32'(e.ea));
            chk("done_errCause", 32'(errCause), 32'(e.ec));
            $display("completion cycle %0d busErr=%0b sCS_=%b errValid=%0b errAddr=%0h errCause=%0b",
                     cyc, busErr, sCS_, errValid, errAddr, errCause);
         end
      end
   end

   initial begin
      logic [AW-1:0] a;
      logic [AW-1:0] t1;
      reset  = 1'b1;
      mAS_   = 1'b1;
      mAddr  = '0;
      sRdy_  = '1;
      errClr = 1'b0;
      m_ev   = 1'b0;
      m_ea   = '0;
      m_ec   = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      chk_reset_vals("reset");

      // Normal access to slave 2, unrelated slave 5 ready early, slave 2 ready on 3rd ACCESS cycle.
      a = mk_addr(3'd2, 27'h00ABCD);
      step(); mAS_ = 1'b0; mAddr = a;
      expect_done(3, 1'b0, 6'b111011);
      step(); sRdy_ = 6'b011111;
      @(negedge clk) chk("cs_acc1", 32'(sCS_), 32'h3B);
      step(); sRdy_ = '1;
      @(negedge clk) chk("cs_acc2", 32'(sCS_), 32'h3B);
      step(); sRdy_ = 6'b111011;
      @(negedge clk) chk("cs_acc3", 32'(sCS_), 32'h3B);
      step(); mAS_ = 1'b1; sRdy_ = '1;
      @(negedge clk) chk("cs_after_done", 32'(sCS_), 32'h3F);

      // Unmapped index 7.
      a = mk_addr(3'd7, 27'h1234567);
      step(); mAS_ = 1'b0; mAddr = a;
      m_ev = 1'b1; m_ea = a; m_ec = 1'b0;
      expect_done(1, 1'b1, 6'h3F);
      step();
      @(negedge clk) chk("cs_unmapped", 32'(sCS_), 32'h3F);
      step(); mAS_ = 1'b1;

      // Clear the log.
      step(); errClr = 1'b1;
      step(); errClr = 1'b0; m_ev = 1'b0;
      @(negedge clk) chk("errclr", 32'(errValid), 32'd0);

      // First timeout: ERROR after 4 ACCESS cycles.
      t1 = mk_addr(3'd4, 27'h00F0F0);
      step(); mAS_ = 1'b0; mAddr = t1;
      m_ev = 1'b1; m_ea = t1; m_ec = 1'b1;
      expect_done(5, 1'b1, 6'h3F);
      repeat (5) step();
      step(); mAS_ = 1'b1;

      // Second timeout: log keeps the first address.
      a = mk_addr(3'd1, 27'h0055AA);
      step(); mAS_ = 1'b0; mAddr = a;
      expect_done(5, 1'b1, 6'h3F);
      repeat (5) step();
      step(); mAS_ = 1'b1;

      // Ready on the terminal-count cycle wins over the watchdog.
      a = mk_addr(3'd3, 27'h000777);
      step(); mAS_ = 1'b0; mAddr = a;
      expect_done(4, 1'b0, 6'b110111);
      repeat (3) step();
      step(); sRdy_ = 6'b110111;
      step(); mAS_ = 1'b1; sRdy_ = '1;

      // Master abort in the 3rd ACCESS cycle.
      a = mk_addr(3'd0, 27'h000ABC);
      step(); mAS_ = 1'b0; mAddr = a;
      step();
      step();
      step(); mAS_ = 1'b1;
      @(negedge clk);
      chk("cs_abort_hold", 32'(sCS_), 32'h3E);
      chk("mrdy_abort", 32'(mRdy_), 32'd1);
      step();
      @(negedge clk) chk("cs_abort_rel", 32'(sCS_), 32'h3F);

      // Reset in the middle of an access with the log populated.
      a = mk_addr(3'd5, 27'h000001);
      step(); mAS_ = 1'b0; mAddr = a;
      step();
      step(); reset = 1'b1;
      step(); reset = 1'b0; mAS_ = 1'b1;
      m_ev = 1'b0; m_ea = '0; m_ec = 1'b0;
      chk_reset_vals("midreset");

      // Logged error, then errClr coinciding with a new error entry.
      a = mk_addr(3'd6, 27'h00BEEF);
      step(); mAS_ = 1'b0; mAddr = a;
      m_ev = 1'b1; m_ea = a; m_ec = 1'b0;
      expect_done(1, 1'b1, 6'h3F);
      step();
      step(); mAS_ = 1'b1;
      a = mk_addr(3'd7, 27'h00CAFE);
      step(); mAS_ = 1'b0; mAddr = a; errClr = 1'b1;
      m_ea = a;
      expect_done(1, 1'b1, 6'h3F);
      step(); errClr = 1'b0;
      step(); mAS_ = 1'b1;

      repeat (3) step();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
